register_dump_unit: RTL and testbench



---
 rtl/register_dump_unit.sv | 155 +++++++++++++++
 tb/tb_register_dump_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/register_dump_unit.sv
// Debug read-out engine: walks a register-file read port from FIRST_REG to LAST_REG and streams
// a header byte followed by each 32-bit value as four little-endian bytes on a valid/ready link.
module register_dump_unit #(
  parameter int unsigned FIRST_REG   = 0,
  parameter int unsigned LAST_REG    = 31,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [4:0]  readAddress,
  input  logic [31:0] readData,
  output logic [7:0]  byteOut,
  output logic        byteValid,
  input  logic        byteReady
);

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned COUNT_W = 2;

  localparam logic [ADDR_W-1:0]  FIRST_ADDR = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(LAST_REG);
  localparam logic [COUNT_W-1:0] LAST_BYTE  = COUNT_W'(3);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    LOAD   = 2'd2,
    SEND   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [DATA_W-1:0]   shift;
  logic [COUNT_W-1:0]  byte_count;

  logic xfer_c;
  logic last_byte_c;
  logic last_reg_c;

  // Outputs are decoded from registers only, so byteReady never reaches byteValid/byteOut.
  assign xfer_c      = byteValid && byteReady;
  assign last_byte_c = (byte_count == LAST_BYTE);
  assign last_reg_c  = (readAddress == LAST_ADDR);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:   if (start)  state_next = HEADER;
        HEADER: if (xfer_c) state_next = LOAD;
        LOAD:   state_next = SEND;
        SEND: begin
          if (xfer_c && last_byte_c) begin
            state_next = last_reg_c ? IDLE : LOAD;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    busy      = 1'b0;
    byteValid = 1'b0;
    byteOut   = '0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
      end
      HEADER: begin
        busy      = 1'b1;
        byteValid = 1'b1;
        byteOut   = HEADER_BYTE;
      end
      LOAD: begin
        busy = 1'b1;
      end
      SEND: begin
        busy      = 1'b1;
        byteValid = 1'b1;
        byteOut   = shift[BYTE_W-1:0];
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Datapath: read address walk, capture/shift register, byte counter and done pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      readAddress <= FIRST_ADDR;
      shift       <= '0;
      byte_count  <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        readAddress <= FIRST_ADDR;
        byte_count  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              readAddress <= FIRST_ADDR;
            end
          end
          HEADER: begin
            byte_count <= '0;
          end
          LOAD: begin
            shift      <= readData;
            byte_count <= '0;
          end
          SEND: begin
            if (xfer_c) begin
              if (!last_byte_c) begin
                shift      <= {BYTE_W'(0), shift[DATA_W-1:BYTE_W]};
                byte_count <= byte_count + COUNT_W'(1);
              end else if (!last_reg_c) begin
                readAddress <= readAddress + ADDR_W'(1);
              end else begin
                readAddress <= FIRST_ADDR;
                done        <= 1'b1;
              end
            end
          end
          default: begin
            byte_count <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_register_dump_unit.sv
// Scoreboard bench for register_dump_unit: expected bytes are queued at start and popped on
// every handshake; a second instance covers the single-register parameterisation.
module tb_register_dump_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        byteReady = 1'b0;
  logic        busy, done, byteValid;
  logic [4:0]  readAddress;
  logic [31:0] readData;
  logic [7:0]  byteOut;

  logic        start_b = 1'b0;
  logic        byteReady_b = 1'b0;
  logic        busy_b, done_b, byteValid_b;
  logic [4:0]  readAddress_b;
  logic [31:0] readData_b;
  logic [7:0]  byteOut_b;

  logic [7:0] q[$];
  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] reg_val(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : 32'h0100_0000 + 32'(a);
  endfunction

  assign readData   = reg_val(readAddress);
  assign readData_b = (readAddress_b == 5'd5) ? 32'hDEAD_BEEF : reg_val(readAddress_b);

  register_dump_unit dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .readAddress(readAddress), .readData(readData),
    .byteOut(byteOut), .byteValid(byteValid), .byteReady(byteReady)
  );

  register_dump_unit #(.FIRST_REG(5), .LAST_REG(5), .HEADER_BYTE(8'hA5)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .abort(1'b0),
    .busy(busy_b), .done(done_b), .readAddress(readAddress_b), .readData(readData_b),
    .byteOut(byteOut_b), .byteValid(byteValid_b), .byteReady(byteReady_b)
  );

  task automatic push_full_dump();
    logic [31:0] v;
    q.push_back(8'hA5);
    for (int r = 0; r < 32; r++) begin
      v = reg_val(5'(r));
      for (int b = 0; b < 4; b++) q.push_back(v[8*b +: 8]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; byteReady = 1'b0;
    start_b = 1'b0; byteReady_b = 1'b0;
    repeat (3) @(negedge clock);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", done); end
    compared++; if (byteValid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", byteValid); end
    compared++; if (byteOut !== 8'h00) begin mismatched++; $display("FAIL reset_byte: got %h want 00", byteOut); end
    compared++; if (readAddress !== 5'd0) begin mismatched++; $display("FAIL reset_addr: got %0d want 0", readAddress); end
    compared++; if (readAddress_b !== 5'd5) begin mismatched++; $display("FAIL reset_addr_b: got %0d want 5", readAddress_b); end
    reset = 1'b0;
    @(negedge clock);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  // Full dump; rnd adds random back-pressure and ignored start pulses while busy
  task automatic test_dump(input bit rnd);
    int n;
    bit seen_done;
    bit pv, pr;
    logic [7:0] pb, exp;
    q.delete();
    push_full_dump();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    compared++; if (busy !== 1'b1 || byteValid !== 1'b1) begin
      mismatched++; $display("FAIL dump_hdr_entry: busy=%b valid=%b want 1/1", busy, byteValid); end
    compared++; if (readAddress !== 5'd0) begin
      mismatched++; $display("FAIL dump_hdr_addr: got %0d want 0", readAddress); end
    n = 0; seen_done = 1'b0; pv = 1'b0; pr = 1'b1; pb = 8'h00;
    while (n < 3000) begin
      if (done) begin seen_done = 1'b1; break; end
      if (pv && !pr) begin
        compared++;
        if (byteValid !== 1'b1 || byteOut !== pb) begin
          mismatched++; $display("FAIL stall_hold cyc %0d: valid=%b byte=%h want 1/%h", n, byteValid, byteOut, pb);
        end
      end
      byteReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (rnd && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (byteValid && byteReady) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++; $display("FAIL dump_extra_byte: got %h want none", byteOut);
        end else begin
          exp = q.pop_front();
          if (byteOut !== exp) begin mismatched++; $display("FAIL dump_byte cyc %0d: got %h want %h", n, byteOut, exp); end
        end
      end
      pv = byteValid; pr = byteReady; pb = byteOut;
      @(negedge clock);
      n++;
    end
    start = 1'b0; byteReady = 1'b0;
    compared++; if (!seen_done) begin mismatched++; $display("FAIL dump_timeout: got no done want done"); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL done_busy: got %b want 0", busy); end
    if (!rnd) begin
      compared++; if (n != 161) begin mismatched++; $display("FAIL done_latency: got %0d want 161", n); end
    end
    compared++; if (q.size() != 0) begin mismatched++; $display("FAIL dump_missing: got %0d left want 0", q.size()); end
    @(negedge clock);
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL done_width: got %b want 0", done); end
  endtask

  task automatic test_single_reg();
    int n;
    bit seen_done;
    logic [7:0] exp;
    q.delete();
    q.push_back(8'hA5); q.push_back(8'hEF); q.push_back(8'hBE); q.push_back(8'hAD); q.push_back(8'hDE);
    start_b = 1'b1; byteReady_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    n = 0; seen_done = 1'b0;
    while (n < 100) begin
      if (done_b) begin seen_done = 1'b1; break; end
      compared++; if (readAddress_b !== 5'd5) begin mismatched++; $display("FAIL single_addr: got %0d want 5", readAddress_b); end
      if (byteValid_b) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++; $display("FAIL single_extra: got %h want none", byteOut_b);
        end else begin
          exp = q.pop_front();
          if (byteOut_b !== exp) begin mismatched++; $display("FAIL single_byte: got %h want %h", byteOut_b, exp); end
        end
      end
      @(negedge clock);
      n++;
    end
    byteReady_b = 1'b0;
    compared++; if (!seen_done || n != 6) begin mismatched++; $display("FAIL single_done: got cyc %0d want 6", n); end
    compared++; if (busy_b !== 1'b0 || q.size() != 0) begin
      mismatched++; $display("FAIL single_end: busy=%b left=%0d want 0/0", busy_b, q.size()); end
    compared++; if (readAddress_b !== 5'd5) begin mismatched++; $display("FAIL single_addr_end: got %0d want 5", readAddress_b); end
  endtask

  // Abort while x3 byte 1 is on the link
  task automatic test_abort();
    int n, xfers;
    logic [7:0] exp;
    q.delete();
    push_full_dump();
    start = 1'b1; byteReady = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0; xfers = 0;
    while (n < 500 && !(xfers == 14 && byteValid)) begin
      if (byteValid) begin
        exp = q.pop_front();
        compared++; if (byteOut !== exp) begin mismatched++; $display("FAIL abort_pre_byte: got %h want %h", byteOut, exp); end
        xfers++;
      end
      @(negedge clock);
      n++;
    end
    compared++; if (readAddress !== 5'd3 || byteOut !== 8'h00 || n >= 500) begin
      mismatched++; $display("FAIL abort_point: addr=%0d byte=%h cyc=%0d want 3/00", readAddress, byteOut, n); end
    abort = 1'b1; byteReady = 1'b0;
    @(negedge clock);
    abort = 1'b0;
    compared++; if (byteValid !== 1'b0 || busy !== 1'b0) begin
      mismatched++; $display("FAIL abort_idle: valid=%b busy=%b want 0/0", byteValid, busy); end
    compared++; if (readAddress !== 5'd0) begin mismatched++; $display("FAIL abort_addr: got %0d want 0", readAddress); end
    for (int i = 0; i < 3; i++) begin
      compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL abort_done: got %b want 0", done); end
      @(negedge clock);
    end
    q.delete();
  endtask

  // start held high for 300 cycles yields exactly two back-to-back dumps
  task automatic test_back_to_back();
    int n, dones;
    int done_at[2];
    logic [7:0] exp;
    q.delete();
    push_full_dump();
    push_full_dump();
    byteReady = 1'b1; start = 1'b1;
    n = 0; dones = 0; done_at[0] = -1; done_at[1] = -1;
    while (dones < 2 && n < 1000) begin
      if (done) begin done_at[dones] = n; dones++; end
      if (byteValid) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++; $display("FAIL b2b_extra: got %h want none", byteOut);
        end else begin
          exp = q.pop_front();
          if (byteOut !== exp) begin mismatched++; $display("FAIL b2b_byte cyc %0d: got %h want %h", n, byteOut, exp); end
        end
      end
      @(negedge clock);
      n++;
      if (n >= 300) start = 1'b0;
    end
    start = 1'b0; byteReady = 1'b0;
    compared++; if (done_at[0] != 162) begin mismatched++; $display("FAIL b2b_done1: got %0d want 162", done_at[0]); end
    compared++; if (done_at[1] != 324) begin mismatched++; $display("FAIL b2b_done2: got %0d want 324", done_at[1]); end
    compared++; if (q.size() != 0) begin mismatched++; $display("FAIL b2b_missing: got %0d want 0", q.size()); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_third: busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_load();
    start = 1'b1; byteReady = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    compared++; if (busy !== 1'b1 || byteValid !== 1'b0) begin
      mismatched++; $display("FAIL load_state: busy=%b valid=%b want 1/0", busy, byteValid); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; byteReady = 1'b0;
    compared++; if (busy !== 1'b0 || done !== 1'b0 || byteValid !== 1'b0) begin
      mismatched++; $display("FAIL rst_load_ctl: busy=%b done=%b valid=%b want 0/0/0", busy, done, byteValid); end
    compared++; if (byteOut !== 8'h00 || readAddress !== 5'd0) begin
      mismatched++; $display("FAIL rst_load_data: byte=%h addr=%0d want 00/0", byteOut, readAddress); end
    @(negedge clock);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_load_stay: busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_dump(1'b0);
    test_dump(1'b1);
    test_single_reg();
    test_abort();
    test_dump(1'b0);
    test_back_to_back();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
